alu_acc_ctrl: RTL

//   Accumulator and sequencing stage around the 8-bit combinational add/subtract unit.
//   - Accepts one command per handshake.
//   - Drives the add/sub unit's A/B/select operands; A is the accumulator.
//   - Samples the unit's result and carry/borrow, corrects subtraction, updates accumulator and flags.
//   - Presents the result to the downstream register-file/memory write path via a valid/ready handshake.

---
 rtl/alu_acc_pkg.sv | 25 ++
 rtl/alu_flag_gen.sv | 67 ++++++
 rtl/alu_acc_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_acc_pkg.sv
// Shared definitions for the accumulator/sequencer around the 8-bit add/sub unit:
// command opcodes, sequencer state encoding and the datapath width.
package alu_acc_pkg;

    localparam int ALU_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // ADD and SUB go through the external add/sub unit; LOAD and CLR do not.
    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Result correction and flag generation for the accumulator stage.
// The add/sub unit computes A + (B ^ {8{sel}}) with carry-in 0, so a subtract
// arrives one short of A - B; this block adds the missing +1 and folds the
// carry out of that increment into the no-borrow flag.
// Optional macro ALU_OVF_FLAG_EN adds the signed overflow output v.
module alu_flag_gen
    import alu_acc_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] raw_res,
    input  logic       raw_cb,
    output logic [7:0] res,
    output logic       z,
    output logic       c,
`ifdef ALU_OVF_FLAG_EN
    output logic       v,
`endif
    output logic       n
);

    // Select the corrected result and carry for the current opcode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        res = raw_res;
        c   = raw_cb;
        case (op)
            OP_LOAD: begin
                res = b;
                c   = 1'b0;
            end
            OP_CLR: begin
                res = 8'h00;
                c   = 1'b0;
            end
            OP_SUB: begin
                res = raw_res + 8'h01;
                c   = raw_cb | (raw_res == 8'hFF);
            end
            default: begin
                res = raw_res;
                c   = raw_cb;
            end
        endcase
    end

    assign z = (res == 8'h00);
    assign n = res[7];

`ifdef ALU_OVF_FLAG_EN
    // Signed overflow: operands agree (ADD) or differ (SUB) in sign and the result flips it.
    always_comb begin
        v = 1'b0;
        case (op)
            OP_ADD:  v = (a[7] == b[7]) && (res[7] != a[7]);
            OP_SUB:  v = (a[7] != b[7]) && (res[7] != a[7]);
            default: v = 1'b0;
        endcase
    end
`else
    // Operand A only feeds the overflow logic.
    logic unused_a;
    assign unused_a = ^a;
`endif

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator and sequencing stage around the 8-bit combinational add/sub unit.
// Accepts one command per handshake, drives the unit's operands (A = accumulator),
// captures the corrected result into the accumulator and flags, and holds the
// result on a valid/ready interface until the write path takes it.
// Optional macro ALU_OVF_FLAG_EN adds the flag_v signed-overflow output.
module alu_acc_ctrl
    import alu_acc_pkg::*;
#(
    parameter int         DATA_W  = ALU_DATA_W,
    parameter logic [7:0] ACC_RST = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] as_a_o,
    output logic [DATA_W-1:0] as_b_o,
    output logic              as_sel_o,
    input  logic [DATA_W-1:0] as_res_i,
    input  logic              as_cb_i,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              flag_z,
    output logic              flag_c,
`ifdef ALU_OVF_FLAG_EN
    output logic              flag_v,
`endif
    output logic              flag_n
);

    state_e            state;
    op_e               op_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] op_data;

    logic [1:0]        fg_op;
    logic [DATA_W-1:0] fg_b;
    logic [DATA_W-1:0] fg_res;
    logic              fg_z;
    logic              fg_c;
    logic              fg_n;
`ifdef ALU_OVF_FLAG_EN
    logic              fg_v;
`endif

    // Operand registers feed the add/sub unit directly.
    assign as_a_o = acc;
    assign as_b_o = op_data;

    // LOAD/CLR resolve at the accept edge from the live command; ADD/SUB resolve
    // in EXEC from the latched command and the unit's result.
    assign fg_op = (state == ST_IDLE) ? cmd_op   : op_q;
    assign fg_b  = (state == ST_IDLE) ? cmd_data : op_data;

    alu_flag_gen u_flag_gen (
        .op      (fg_op),
        .a       (acc),
        .b       (fg_b),
        .raw_res (as_res_i),
        .raw_cb  (as_cb_i),
        .res     (fg_res),
        .z       (fg_z),
        .c       (fg_c),
`ifdef ALU_OVF_FLAG_EN
        .v       (fg_v),
`endif
        .n       (fg_n)
    );

    // Sequencer: command accept, execute, and result hold with registered handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state     <= ST_IDLE;
            op_q      <= OP_LOAD;
            acc       <= ACC_RST;
            op_data   <= '0;
            as_sel_o  <= 1'b0;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= ACC_RST;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
            flag_v    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_e'(cmd_op);
                        op_data   <= cmd_data;
                        as_sel_o  <= (cmd_op == OP_SUB);
                        cmd_ready <= 1'b0;
                        if (is_arith(cmd_op)) begin
                            state <= ST_EXEC;
                        end else begin
                            acc       <= fg_res;
                            res_data  <= fg_res;
                            flag_z    <= fg_z;
                            flag_c    <= fg_c;
                            flag_n    <= fg_n;
`ifdef ALU_OVF_FLAG_EN
                            flag_v    <= fg_v;
`endif
                            res_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_EXEC: begin
                    acc       <= fg_res;
                    res_data  <= fg_res;
                    flag_z    <= fg_z;
                    flag_c    <= fg_c;
                    flag_n    <= fg_n;
`ifdef ALU_OVF_FLAG_EN
                    flag_v    <= fg_v;
`endif
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
